binary_to_octal_decoder_seq: RTL and testbench

//  Sequenced 3-to-8 decoder: accepts a 3-bit binary code over a valid/ready handshake and drives the matching
//  one-hot select line for a fixed hold time, then an optional guard gap, before accepting the next code.
//  It is the inverse of the octal-to-binary encoder path; it drives one-hot select/strobe lines to downstream loads.

---
 rtl/binary_to_octal_decoder_seq_pkg.sv | 15 +
 rtl/binary_to_octal_decoder_seq_hold_counter.sv | 30 +++
 rtl/binary_to_octal_decoder_seq.sv | 139 +++++++++++++
 tb/tb_binary_to_octal_decoder_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_to_octal_decoder_seq_pkg.sv
// Shared types and helpers for the sequenced 3-to-8 decoder.
package dec_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, GAP} dec_state_t;

   localparam int ONEHOT_W = 8;

   function automatic logic [ONEHOT_W-1:0] onehot8(input logic [2:0] code);
      logic [ONEHOT_W-1:0] v;
      v       = '0;
      v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/binary_to_octal_decoder_seq_hold_counter.sv
// Loadable down-counter with zero flag; times both the hold and the guard gap.
module dec_hold_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/binary_to_octal_decoder_seq.sv
// Sequenced 3-to-8 decoder: one-hot y for HOLD_CYCLES, then GAP_CYCLES of guard.
// Optional sticky "seen" mask is enabled by defining DEC_SEEN_MASK_EN.
//
// state | meaning
// IDLE  | ready for a code (when en=1)
// DRIVE | y one-hot, hold timer running
// GAP   | y forced to 0, guard timer running
module binary_to_octal_decoder_seq
   import dec_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          in_code,
`ifdef DEC_SEEN_MASK_EN
   input  logic                seen_clr,
   output logic [ONEHOT_W-1:0] seen,
`endif
   output logic [ONEHOT_W-1:0] y,
   output logic                y_valid,
   output logic                busy,
   output logic                done
);

   localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   dec_state_t          state, state_nxt;
   logic [ONEHOT_W-1:0] y_nxt;
   logic                y_valid_nxt, done_nxt;
   logic                cnt_clr, cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]    cnt_ld_val;
   logic                xfer;

   assign in_ready = en && (state == IDLE);
   assign xfer     = in_valid && in_ready;
   assign busy     = (state == DRIVE) || (state == GAP);

   dec_hold_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (cnt_ld_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         y       <= '0;
         y_valid <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         y       <= y_nxt;
         y_valid <= y_valid_nxt;
         done    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      y_nxt       = y;
      y_valid_nxt = y_valid;
      done_nxt    = 1'b0;
      cnt_clr     = 1'b0;
      cnt_load    = 1'b0;
      cnt_ld_val  = HOLD_LD;
      cnt_dec     = 1'b0;
      // dropping en aborts silently: no done pulse
      if (!en && (state != IDLE)) begin
         state_nxt   = IDLE;
         y_nxt       = '0;
         y_valid_nxt = 1'b0;
         cnt_clr     = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  state_nxt   = DRIVE;
                  y_nxt       = onehot8(in_code);
                  y_valid_nxt = 1'b1;
                  cnt_load    = 1'b1;
                  cnt_ld_val  = HOLD_LD;
               end
            end
            DRIVE: begin
               if (!cnt_zero) begin
                  cnt_dec = 1'b1;
               end else begin
                  y_nxt       = '0;
                  y_valid_nxt = 1'b0;
                  done_nxt    = 1'b1;
                  if (GAP_CYCLES == 0) begin
                     state_nxt = IDLE;
                  end else begin
                     state_nxt  = GAP;
                     cnt_load   = 1'b1;
                     cnt_ld_val = GAP_LD;
                  end
               end
            end
            GAP: begin
               if (!cnt_zero) cnt_dec = 1'b1;
               else           state_nxt = IDLE;
            end
            default: begin
               state_nxt   = IDLE;
               y_nxt       = '0;
               y_valid_nxt = 1'b0;
               cnt_clr     = 1'b1;
            end
         endcase
      end
   end

`ifdef DEC_SEEN_MASK_EN
   // a transfer coinciding with a clear restarts the mask from the new code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen <= '0;
      end else if (xfer) begin
         seen <= seen_clr ? onehot8(in_code) : (seen | onehot8(in_code));
      end else if (seen_clr) begin
         seen <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_binary_to_octal_decoder_seq.sv
// Bench for binary_to_octal_decoder_seq: instance 0 uses HOLD=4/GAP=1, instance 1 HOLD=1/GAP=0.
module tb_binary_to_octal_decoder_seq;

   localparam int H0 = 4, G0 = 1, H1 = 1, G1 = 0;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       en[2]   = '{1'b0, 1'b0};
   logic       vld[2]  = '{1'b0, 1'b0};
   logic [2:0] code[2] = '{3'd0, 3'd0};
   logic       rdy[2], yv[2], busy[2], done[2];
   logic [7:0] y[2];
`ifdef DEC_SEEN_MASK_EN
   logic       seen_clr0 = 1'b0;
   logic       seen_clr1 = 1'b0;
   logic [7:0] seen0, seen1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   binary_to_octal_decoder_seq #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
      .in_code(code[0]),
`ifdef DEC_SEEN_MASK_EN
      .seen_clr(seen_clr0), .seen(seen0),
`endif
      .y(y[0]), .y_valid(yv[0]), .busy(busy[0]), .done(done[0]));

   binary_to_octal_decoder_seq #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
      .in_code(code[1]),
`ifdef DEC_SEEN_MASK_EN
      .seen_clr(seen_clr1), .seen(seen1),
`endif
      .y(y[1]), .y_valid(yv[1]), .busy(busy[1]), .done(done[1]));

   // Model: age = cycles since the accepting edge (-1 when idle).
   int         age[2]   = '{-1, -1};
   logic [2:0] mcode[2] = '{3'd0, 3'd0};
   logic       mdone[2] = '{1'b0, 1'b0};
   int         cyc      = 0;
   int         acc0[$];
   int         acc1[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            age[i]   = -1;
            mdone[i] = 1'b0;
         end
      end else begin
         cyc++;
         for (int i = 0; i < 2; i++) begin
            int hh, gg;
            hh = (i == 0) ? H0 : H1;
            gg = (i == 0) ? G0 : G1;
            mdone[i] = 1'b0;
            if (age[i] < 0) begin
               if (en[i] && vld[i]) begin
                  age[i]   = 0;
                  mcode[i] = code[i];
                  if (i == 0) acc0.push_back(cyc);
                  else        acc1.push_back(cyc);
               end
            end else if (!en[i]) begin
               age[i] = -1;
            end else begin
               if (age[i] == hh - 1) mdone[i] = 1'b1;
               age[i]++;
               if (age[i] >= hh + gg) age[i] = -1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int         hh;
         logic [7:0] one, ey;
         hh  = (i == 0) ? H0 : H1;
         one = 8'h01;
         ey  = (age[i] >= 0 && age[i] < hh) ? (one << mcode[i]) : 8'h00;
         chk($sformatf("m%0d_y", i),       32'(y[i]),    32'(ey));
         chk($sformatf("m%0d_yvalid", i),  32'(yv[i]),   32'(ey != 8'h00));
         chk($sformatf("m%0d_busy", i),    32'(busy[i]), 32'(age[i] >= 0));
         chk($sformatf("m%0d_done", i),    32'(done[i]), 32'(mdone[i]));
         chk($sformatf("m%0d_inready", i), 32'(rdy[i]),  32'(en[i] && age[i] < 0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input int i);
      int n;
      n = 0;
      while (!rdy[i] && n < 50) begin
         tick();
         n++;
      end
      chk("wait_ready", 32'(rdy[i]), 32'd1);
   endtask

   logic [7:0] sweep[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

   initial begin
      int base, k, n;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      chk("reset_y", 32'(y[0]), 32'h0);
      chk("reset_busy", 32'(busy[0]), 32'h0);
      chk("reset_done", 32'(done[0]), 32'h0);
      tick();

      // 1: single code 5
      en[0] = 1'b1; vld[0] = 1'b1; code[0] = 3'd5;
      tick();
      vld[0] = 1'b0; code[0] = 3'd0;
      for (int c = 0; c < 4; c++) begin
         chk("t1_hold_y", 32'(y[0]), 32'h20);
         tick();
      end
      chk("t1_after_y", 32'(y[0]), 32'h0);
      chk("t1_done", 32'(done[0]), 32'h1);
      chk("t1_gap_ready", 32'(rdy[0]), 32'h0);
      tick();
      chk("t1_done_once", 32'(done[0]), 32'h0);
      chk("t1_ready_back", 32'(rdy[0]), 32'h1);

      // 2: sweep with in_valid held
      base = acc0.size();
      k = 0; n = 0;
      vld[0] = 1'b1; code[0] = 3'd0;
      while (k < 8 && n < 100) begin
         tick();
         n++;
         if (acc0.size() > base + k) begin
            chk("t2_sweep_y", 32'(y[0]), 32'(sweep[k]));
            k++;
            code[0] = 3'(k);
         end
      end
      vld[0] = 1'b0;
      chk("t2_accepts", 32'(k), 32'd8);
      for (int j = base + 1; j < acc0.size(); j++)
         chk("t2_spacing", 32'(acc0[j] - acc0[j-1]), 32'd6);

      // 3: abort by dropping en in the 2nd DRIVE cycle
      wait_rdy(0);
      vld[0] = 1'b1; code[0] = 3'd2;
      tick();
      vld[0] = 1'b0;
      chk("t3_y", 32'(y[0]), 32'h04);
      tick();
      en[0] = 1'b0;
      tick();
      chk("t3_abort_y", 32'(y[0]), 32'h0);
      chk("t3_abort_done", 32'(done[0]), 32'h0);
      chk("t3_abort_ready", 32'(rdy[0]), 32'h0);
      base = acc0.size();
      vld[0] = 1'b1; code[0] = 3'd3;
      tick(); tick();
      chk("t3_no_xfer_y", 32'(y[0]), 32'h0);
      chk("t3_no_accept", 32'(acc0.size() - base), 32'd0);
      vld[0] = 1'b0;
      en[0] = 1'b1;
      #1 chk("t3_ready_en", 32'(rdy[0]), 32'h1);
      tick();

      // 4: HOLD=1, GAP=0 instance
      base = acc1.size();
      en[1] = 1'b1; vld[1] = 1'b1; code[1] = 3'd3;
      tick();
      chk("t4_y", 32'(y[1]), 32'h08);
      code[1] = 3'd6;
      tick();
      chk("t4_y_off", 32'(y[1]), 32'h0);
      chk("t4_done", 32'(done[1]), 32'h1);
      tick();
      chk("t4_y2", 32'(y[1]), 32'h40);
      vld[1] = 1'b0;
      chk("t4_accepts", 32'(acc1.size() - base), 32'd2);
      if (acc1.size() - base == 2)
         chk("t4_spacing", 32'(acc1[base+1] - acc1[base]), 32'd2);
      tick(); tick();

      // 5: async reset mid-hold on code 7
      wait_rdy(0);
      vld[0] = 1'b1; code[0] = 3'd7;
      tick();
      vld[0] = 1'b0;
      chk("t5_y", 32'(y[0]), 32'h80);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_y", 32'(y[0]), 32'h0);
      chk("t5_async_yvalid", 32'(yv[0]), 32'h0);
      chk("t5_async_busy", 32'(busy[0]), 32'h0);
      en[0] = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
      chk("t5_no_done", 32'(done[0]), 32'h0);
      chk("t5_ready_en0", 32'(rdy[0]), 32'h0);
      en[0] = 1'b1;
      #1 chk("t5_ready_en1", 32'(rdy[0]), 32'h1);

`ifdef DEC_SEEN_MASK_EN
      // 6: sticky mask
      chk("t6_seen_reset", 32'(seen0), 32'h0);
      for (int j = 0; j < 3; j++) begin
         wait_rdy(0);
         vld[0] = 1'b1; code[0] = (j == 1) ? 3'd4 : 3'd1;
         tick();
         vld[0] = 1'b0;
      end
      chk("t6_seen_acc", 32'(seen0), 32'h12);
      wait_rdy(0);
      vld[0] = 1'b1; code[0] = 3'd6; seen_clr0 = 1'b1;
      tick();
      vld[0] = 1'b0; seen_clr0 = 1'b0;
      chk("t6_seen_clr_xfer", 32'(seen0), 32'h40);
      seen_clr0 = 1'b1;
      tick();
      seen_clr0 = 1'b0;
      chk("t6_seen_clr", 32'(seen0), 32'h0);
`endif

      repeat (8) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
